fetch_sequencer: RTL and testbench

Instruction-fetch sequencer that sits directly upstream of the instruction register (the active-low-load `Register` instance). It owns the fetch program counter and drives a request/ready read handshake to program memory. For each returned word it presents the data and a one-cycle active-low load strobe to the instruction register, then holds until the execute stage signals completion. It also handles sequential increment, branch redirect and memory-timeout faulting.

---
 rtl/fetch_sequencer.sv | 128 ++++++++++++
 tb/tb_fetch_sequencer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: owns the fetch PC and runs the program-memory read handshake.
// Min 3 cycles from Run/Advance to IR capture; waits on MemRdy, faults after TimeoutCycles idle WAIT edges.
module fetch_sequencer #(
  parameter int                   DataWidth     = 16,
  parameter int                   AddrWidth     = 16,
  parameter logic [AddrWidth-1:0] ResetVector   = '0,
  parameter int                   TimeoutCycles = 8
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Run,
  output logic [AddrWidth-1:0] MemAddr,
  output logic                 MemRd,
  input  logic                 MemRdy,
  input  logic [DataWidth-1:0] MemData,
  output logic [DataWidth-1:0] IR_DIn,
  output logic                 IR_LD,
  output logic [AddrWidth-1:0] PC,
  input  logic                 Advance,
  input  logic                 Branch,
  input  logic [AddrWidth-1:0] BranchAddr,
  output logic                 Busy,
  output logic                 Fault
);

  localparam int                  CntWidth = $clog2(TimeoutCycles + 1);
  localparam logic [CntWidth-1:0] TmoLast  = CntWidth'(TimeoutCycles - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_LOAD,
    S_HOLD,
    S_FAULT
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [AddrWidth-1:0] r_fetch_pc;
  logic [AddrWidth-1:0] w_fetch_pc_nxt;
  logic [AddrWidth-1:0] r_pc;
  logic [DataWidth-1:0] r_ir_din;
  logic [CntWidth-1:0]  r_tmo_cnt;
  logic [CntWidth-1:0]  w_tmo_cnt_nxt;
  logic                 w_capture;
  logic                 w_pc_load;
  logic                 w_tmo_hit;

  // The edge that would make the count reach TimeoutCycles is the faulting edge.
  assign w_tmo_hit = (r_tmo_cnt == TmoLast);

  always_comb begin
    w_state_nxt    = r_state;
    w_fetch_pc_nxt = r_fetch_pc;
    w_tmo_cnt_nxt  = r_tmo_cnt;
    w_capture      = 1'b0;
    w_pc_load      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (Run) w_state_nxt = S_REQ;
      end
      S_REQ: begin
        w_state_nxt   = S_WAIT;
        w_tmo_cnt_nxt = '0;
      end
      S_WAIT: begin
        if (MemRdy) begin
          w_state_nxt = S_LOAD;
          w_capture   = 1'b1;
        end else begin
          w_tmo_cnt_nxt = r_tmo_cnt + 1'b1;
          if (w_tmo_hit) w_state_nxt = S_FAULT;
        end
      end
      S_LOAD: begin
        w_state_nxt = S_HOLD;
        w_pc_load   = 1'b1;
      end
      S_HOLD: begin
        if (Advance) begin
          w_fetch_pc_nxt = Branch ? BranchAddr : r_fetch_pc + 1'b1;
          w_state_nxt    = Run ? S_REQ : S_IDLE;
        end
      end
      S_FAULT: begin
        w_state_nxt = S_FAULT;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state   <= S_IDLE;
      r_tmo_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_tmo_cnt <= w_tmo_cnt_nxt;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_fetch_pc <= ResetVector;
      r_pc       <= ResetVector;
      r_ir_din   <= '0;
    end else begin
      r_fetch_pc <= w_fetch_pc_nxt;
      if (w_capture) r_ir_din <= MemData;
      if (w_pc_load) r_pc <= r_fetch_pc;
    end
  end

  assign MemAddr = r_fetch_pc;
  assign MemRd   = (r_state == S_REQ) || (r_state == S_WAIT);
  assign IR_LD   = (r_state != S_LOAD);
  assign IR_DIn  = r_ir_din;
  assign PC      = r_pc;
  assign Busy    = (r_state == S_REQ) || (r_state == S_WAIT) || (r_state == S_LOAD);
  assign Fault   = (r_state == S_FAULT);

  a_ld_single_cycle: assert property (@(posedge Clk) disable iff (!Reset) !IR_LD |=> IR_LD);
  a_fault_sticky:    assert property (@(posedge Clk) disable iff (!Reset) Fault |=> Fault);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: randomized fetch stream scored against an address/data model, plus directed corner cases.
module tb_fetch_sequencer;
  localparam int DW = 16;
  localparam int AW = 16;
  localparam int NF = 24;

  logic          Clk = 1'b0;
  logic          Reset = 1'b0;
  logic          Run = 1'b0;
  logic          MemRdy = 1'b0;
  logic [DW-1:0] MemData = '0;
  logic          Advance = 1'b0;
  logic          Branch = 1'b0;
  logic [AW-1:0] BranchAddr = '0;
  logic [AW-1:0] MemAddr;
  logic [AW-1:0] PC;
  logic [DW-1:0] IR_DIn;
  logic          MemRd;
  logic          IR_LD;
  logic          Busy;
  logic          Fault;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            waits;
  } exp_t;
  exp_t exp_q[$];

  fetch_sequencer #(
    .DataWidth(DW), .AddrWidth(AW), .ResetVector(16'h0000), .TimeoutCycles(8)
  ) dut (
    .Clk(Clk), .Reset(Reset), .Run(Run), .MemAddr(MemAddr), .MemRd(MemRd),
    .MemRdy(MemRdy), .MemData(MemData), .IR_DIn(IR_DIn), .IR_LD(IR_LD), .PC(PC),
    .Advance(Advance), .Branch(Branch), .BranchAddr(BranchAddr), .Busy(Busy), .Fault(Fault)
  );

  always #5 Clk = ~Clk;

  task automatic chkw(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    chkw(name, {31'b0, act}, {31'b0, exp});
  endtask

  function automatic logic [AW-1:0] next_pc(input logic [AW-1:0] pc, input bit br,
                                            input logic [AW-1:0] tgt);
    int n;
    n = br ? int'(tgt) : (int'(pc) + 1) % 65536;
    return AW'(n);
  endfunction

  // Scoreboard monitor: checks request address, loaded word, load latency and PC update.
  initial begin : monitor
    int   cyc = 0;
    int   req_cyc = 0;
    bit   prev_rd = 1'b0;
    bit   pend = 1'b0;
    logic [AW-1:0] pend_addr = '0;
    exp_t e;
    forever begin
      @(negedge Clk);
      cyc++;
      if (pend) begin
        chkw("pc_after_load", 32'(PC), 32'(pend_addr));
        chkb("ir_ld_one_cycle", IR_LD, 1'b1);
        chkb("busy_in_hold", Busy, 1'b0);
        pend = 1'b0;
      end
      if (MemRd && !prev_rd && exp_q.size() > 0) begin
        req_cyc = cyc;
        chkw("fetch_addr", 32'(MemAddr), 32'(exp_q[0].addr));
      end
      if (!IR_LD) begin
        if (exp_q.size() == 0) begin
          chkb("unexpected_load", IR_LD, 1'b1);
        end else begin
          e = exp_q.pop_front();
          chkw("ir_din", 32'(IR_DIn), 32'(e.data));
          chkw("load_latency", 32'(cyc - req_cyc), 32'(2 + e.waits));
          pend      = 1'b1;
          pend_addr = e.addr;
        end
      end
      prev_rd = MemRd;
    end
  end

  // Acts as program memory for one fetch; returns at the negedge inside LOAD.
  task automatic serve(input int waits, input logic [DW-1:0] data, input bit drop);
    int guard = 0;
    while (!MemRd && guard < 20) begin
      @(negedge Clk);
      guard++;
    end
    chkb("memrd_seen", MemRd, 1'b1);
    Advance = 1'($urandom_range(0, 1));
    Branch  = 1'($urandom_range(0, 1));
    @(negedge Clk);
    if (drop) Run = 1'b0;
    for (int k = 0; k < waits; k++) begin
      Advance    = 1'($urandom_range(0, 1));
      Branch     = 1'($urandom_range(0, 1));
      BranchAddr = AW'($urandom_range(0, 65535));
      MemData    = DW'($urandom_range(0, 65535));
      @(negedge Clk);
    end
    Advance = 1'b0;
    Branch  = 1'b0;
    MemRdy  = 1'b1;
    MemData = data;
    @(negedge Clk);
    MemRdy  = 1'b0;
    MemData = DW'($urandom_range(0, 65535));
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stim
    int            waits_a[NF];
    logic [DW-1:0] data_a[NF];
    bit            br_a[NF];
    logic [AW-1:0] tgt_a[NF];
    logic [AW-1:0] model_pc;
    exp_t          e;

    for (int i = 0; i < NF; i++) begin
      waits_a[i] = $urandom_range(0, 7);
      data_a[i]  = DW'($urandom_range(0, 65535));
      br_a[i]    = ($urandom_range(0, 3) == 0);
      tgt_a[i]   = AW'($urandom_range(0, 65535));
    end
    waits_a[0] = 0; data_a[0] = 16'h00A0; br_a[0] = 1'b0;
    waits_a[1] = 3; br_a[1] = 1'b0;
    waits_a[2] = 7; br_a[2] = 1'b1; tgt_a[2] = 16'hFFFF;
    br_a[3] = 1'b0;
    br_a[4] = 1'b1; tgt_a[4] = 16'h1234;
    waits_a[NF-1] = 2; data_a[NF-1] = 16'h5A5A;

    #20;
    chkb("rst_memrd_async", MemRd, 1'b0);
    chkb("rst_ir_ld_async", IR_LD, 1'b1);
    #30;
    @(negedge Clk);
    Reset = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge Clk);
      chkw("rst_memaddr", 32'(MemAddr), 32'h0);
      chkw("rst_pc", 32'(PC), 32'h0);
      chkw("rst_ir_din", 32'(IR_DIn), 32'h0);
      chkb("rst_ir_ld", IR_LD, 1'b1);
      chkb("rst_memrd", MemRd, 1'b0);
      chkb("rst_busy", Busy, 1'b0);
      chkb("rst_fault", Fault, 1'b0);
    end

    model_pc = '0;
    e.addr = model_pc; e.data = data_a[0]; e.waits = waits_a[0];
    exp_q.push_back(e);
    Run = 1'b1;
    for (int i = 0; i < NF; i++) begin
      serve(waits_a[i], data_a[i], i == NF - 1);
      @(negedge Clk);
      chkb("fault_clear", Fault, 1'b0);
      for (int h = 0; h < int'($urandom_range(0, 3)); h++) begin
        Branch     = 1'($urandom_range(0, 1));
        BranchAddr = AW'($urandom_range(0, 65535));
        @(negedge Clk);
        chkb("hold_no_req", MemRd, 1'b0);
      end
      model_pc = next_pc(model_pc, br_a[i], tgt_a[i]);
      if (i < NF - 1) begin
        e.addr = model_pc; e.data = data_a[i+1]; e.waits = waits_a[i+1];
        exp_q.push_back(e);
      end
      Advance    = 1'b1;
      Branch     = br_a[i];
      BranchAddr = tgt_a[i];
      @(negedge Clk);
      Advance = 1'b0;
      Branch  = 1'b0;
    end

    for (int c = 0; c < 3; c++) begin
      chkb("run_drop_idle_memrd", MemRd, 1'b0);
      chkb("run_drop_idle_busy", Busy, 1'b0);
      chkw("run_drop_idle_addr", 32'(MemAddr), 32'(model_pc));
      @(negedge Clk);
    end
    chkw("sb_drained", 32'(exp_q.size()), 32'd0);

    Run = 1'b1;
    @(negedge Clk);
    chkb("tmo_req", MemRd, 1'b1);
    chkw("tmo_req_addr", 32'(MemAddr), 32'(model_pc));
    @(negedge Clk);
    repeat (7) @(negedge Clk);
    chkb("tmo_7_no_fault", Fault, 1'b0);
    chkb("tmo_7_memrd", MemRd, 1'b1);
    @(negedge Clk);
    chkb("tmo_8_fault", Fault, 1'b1);
    chkb("tmo_8_memrd", MemRd, 1'b0);
    chkb("tmo_8_busy", Busy, 1'b0);
    MemRdy = 1'b1;
    for (int c = 0; c < 5; c++) begin
      Advance = ~Advance;
      @(negedge Clk);
      chkb("fault_sticky", Fault, 1'b1);
      chkb("fault_memrd", MemRd, 1'b0);
      chkb("fault_ir_ld", IR_LD, 1'b1);
    end
    MemRdy = 1'b0; Advance = 1'b0; Run = 1'b0;

    Reset = 1'b0;
    repeat (2) @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    chkb("fault_cleared_by_reset", Fault, 1'b0);
    e.addr = 16'h0000; e.data = 16'h1111; e.waits = 1;
    exp_q.push_back(e);
    Run = 1'b1;
    serve(1, 16'h1111, 1'b0);
    @(negedge Clk);
    Advance = 1'b1; Branch = 1'b1; BranchAddr = 16'h4321;
    @(negedge Clk);
    Advance = 1'b0; Branch = 1'b0;
    chkw("mid_req_addr", 32'(MemAddr), 32'h4321);
    @(negedge Clk);
    chkb("mid_in_wait", MemRd, 1'b1);
    #2 Reset = 1'b0;
    #1;
    chkb("mid_rst_memrd", MemRd, 1'b0);
    chkw("mid_rst_memaddr", 32'(MemAddr), 32'h0);
    chkw("mid_rst_pc", 32'(PC), 32'h0);
    chkb("mid_rst_busy", Busy, 1'b0);
    Run = 1'b0; MemRdy = 1'b1;
    @(negedge Clk);
    Reset = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge Clk);
      chkb("mid_rst_no_load", IR_LD, 1'b1);
      chkb("mid_rst_idle", MemRd, 1'b0);
    end
    MemRdy = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
